// File: rtl/signal_sequencer_if.sv
// Handshake and signal-memory bus for the signal sequencer: control inputs,
// the registered ROM read port and the control word presented to the datapath.
interface signal_sequencer_if #(
    parameter int MEMORY_WIDTH = 63,
    parameter int ADDRS_WIDTH  = 4,
    parameter int HOLD_WIDTH   = 8
);
    logic                    start_i;
    logic [ADDRS_WIDTH-1:0]  first_addrs_i;
    logic [ADDRS_WIDTH-1:0]  last_addrs_i;
    logic [HOLD_WIDTH-1:0]   hold_cycles_i;
    logic                    stall_i;
    logic [MEMORY_WIDTH-1:0] rom_signals_data_i;
    logic [ADDRS_WIDTH-1:0]  addrs_rom_signal_o;
    logic                    rd_rom_signals_ld_o;
    logic [MEMORY_WIDTH-1:0] signals_o;
    logic                    signals_valid_o;
    logic                    busy_o;
    logic                    done_o;

    modport master (
        output start_i, first_addrs_i, last_addrs_i, hold_cycles_i, stall_i,
               rom_signals_data_i,
        input  addrs_rom_signal_o, rd_rom_signals_ld_o, signals_o,
               signals_valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, first_addrs_i, last_addrs_i, hold_cycles_i, stall_i,
               rom_signals_data_i,
        output addrs_rom_signal_o, rd_rom_signals_ld_o, signals_o,
               signals_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/signal_sequencer.sv
// Walks a range of signal-memory words, presenting each control word to the
// datapath for a programmable number of cycles, then pulses done.
module signal_sequencer #(
    parameter int MEMORY_WIDTH = 63,
    parameter int ADDRS_WIDTH  = 4,
    parameter int HOLD_WIDTH   = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    signal_sequencer_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]              state;
    logic [ADDRS_WIDTH-1:0]  cur_addr;
    logic [ADDRS_WIDTH-1:0]  last_addr;
    logic [HOLD_WIDTH-1:0]   hold_cycles;
    logic [HOLD_WIDTH-1:0]   hold_cnt;
    logic [MEMORY_WIDTH-1:0] signals_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            cur_addr    <= '0;
            last_addr   <= '0;
            hold_cycles <= '0;
            hold_cnt    <= '0;
            signals_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Range and hold are frozen here so later input changes cannot disturb a run.
                    if (bus.start_i) begin
                        cur_addr    <= bus.first_addrs_i;
                        last_addr   <= bus.last_addrs_i;
                        hold_cycles <= bus.hold_cycles_i;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    signals_q <= bus.rom_signals_data_i;
                    hold_cnt  <= hold_cycles;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!bus.stall_i) begin
                        if (hold_cnt == '0) begin
                            // Word is cleared on exit so the datapath sees zeros outside HOLD.
                            signals_q <= '0;
                            if (cur_addr == last_addr) begin
                                state <= ST_DONE;
                            end else begin
                                cur_addr <= cur_addr + ADDRS_WIDTH'(1);
                                state    <= ST_FETCH;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.addrs_rom_signal_o  = cur_addr;
    assign bus.rd_rom_signals_ld_o = (state == ST_FETCH);
    assign bus.signals_o           = signals_q;
    assign bus.signals_valid_o     = (state == ST_HOLD);
    assign bus.busy_o              = (state != ST_IDLE);
    assign bus.done_o              = (state == ST_DONE);
endmodule

// File: tb/tb_signal_sequencer.sv
// Directed bench for signal_sequencer: a cycle table for a basic three-word run
// plus hand-written sequences for wrap, stall, restart, reset and maximum hold.
module tb_signal_sequencer;
    localparam int MW = 63;
    localparam int AW = 4;
    localparam int HW = 8;

    logic clk = 1'b0;
    logic rst_n;

    signal_sequencer_if #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW), .HOLD_WIDTH(HW)) bus();

    signal_sequencer #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW), .HOLD_WIDTH(HW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [MW-1:0] mem [16];

    // Registered-read signal memory
    always @(posedge clk) begin
        if (bus.rd_rom_signals_ld_o) bus.rom_signals_data_i <= mem[bus.addrs_rom_signal_o];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%s required=%s", name, act, exp);
        end
    endtask

    typedef struct {
        logic          start;
        logic [AW-1:0] first;
        logic [AW-1:0] last;
        logic [HW-1:0] hold;
        logic [AW-1:0] e_addr;
        logic          e_rd;
        logic          e_valid;
        logic          e_busy;
        logic          e_done;
        logic [MW-1:0] e_sig;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic st, input logic [AW-1:0] f, input logic [AW-1:0] l,
                                input logic [HW-1:0] h, input logic [AW-1:0] ea, input logic erd,
                                input logic ev, input logic eb, input logic ed,
                                input logic [MW-1:0] es);
        vec_t v;
        v.start = st; v.first = f; v.last = l; v.hold = h;
        v.e_addr = ea; v.e_rd = erd; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_sig = es;
        return v;
    endfunction

    int    run_q [$];
    int    done_cnt, sig_err, zero_err, first_valid, end_cycle;
    string rd_s, run_s;

    // Launch one sequence and record reads, valid run lengths and done pulses until idle.
    task automatic run_seq(input logic [AW-1:0] f, input logic [AW-1:0] l, input logic [HW-1:0] h,
                           input int st0, input int slen, input int budget);
        logic          prev_v;
        logic [AW-1:0] last_rd;
        bit            fin;
        run_q.delete();
        rd_s = ""; run_s = "";
        done_cnt = 0; sig_err = 0; zero_err = 0; first_valid = -1; end_cycle = -1;
        prev_v = 1'b0; last_rd = '0; fin = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.first_addrs_i = f; bus.last_addrs_i = l;
        bus.hold_cycles_i = h; bus.stall_i = 1'b0;
        for (int c = 1; c <= budget && !fin; c++) begin
            @(negedge clk);
            bus.start_i       = (c == 2);
            bus.first_addrs_i = ~f;
            bus.last_addrs_i  = ~l;
            bus.hold_cycles_i = ~h;
            bus.stall_i       = (c >= st0) && (c < st0 + slen);
            if (bus.rd_rom_signals_ld_o) begin
                last_rd = bus.addrs_rom_signal_o;
                rd_s = {rd_s, $sformatf("%0d,", last_rd)};
            end
            if (bus.signals_valid_o) begin
                if (!prev_v) begin
                    run_q.push_back(1);
                    if (first_valid < 0) first_valid = c;
                end else begin
                    run_q[run_q.size()-1] = run_q[run_q.size()-1] + 1;
                end
                if (bus.signals_o !== mem[last_rd]) sig_err++;
            end else if (bus.signals_o !== '0) begin
                zero_err++;
            end
            if (bus.done_o) done_cnt++;
            prev_v = bus.signals_valid_o;
            if (!bus.busy_o) begin
                fin = 1'b1;
                end_cycle = c;
            end
        end
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        foreach (run_q[i]) run_s = {run_s, $sformatf("%0d,", run_q[i])};
        check("seq_finished", 64'(fin), 64'd1);
        check("seq_sig_content_errs", 64'(sig_err), 64'd0);
        check("seq_nonzero_outside_hold", 64'(zero_err), 64'd0);
        check("seq_done_pulses", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.first_addrs_i = '0; bus.last_addrs_i = '0;
        bus.hold_cycles_i = '0; bus.stall_i = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = MW'(64'h9E37_79B9_7F4A_7C15 * 64'(i + 1));

        #12;
        check("rst_signals", 64'(bus.signals_o), 64'd0);
        check("rst_valid", 64'(bus.signals_valid_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_rd", 64'(bus.rd_rom_signals_ld_o), 64'd0);
        check("rst_addr", 64'(bus.addrs_rom_signal_o), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // first=2 last=4 hold=1; a stray start with other addresses lands in row 7
        tbl[0]  = mk(1, 2, 4, 1, 0, 0, 0, 0, 0, '0);
        tbl[1]  = mk(0, 2, 4, 1, 2, 1, 0, 1, 0, '0);
        tbl[2]  = mk(0, 9, 0, 7, 2, 0, 0, 1, 0, '0);
        tbl[3]  = mk(0, 2, 4, 5, 2, 0, 1, 1, 0, mem[2]);
        tbl[4]  = mk(0, 2, 4, 1, 2, 0, 1, 1, 0, mem[2]);
        tbl[5]  = mk(0, 2, 4, 1, 3, 1, 0, 1, 0, '0);
        tbl[6]  = mk(0, 2, 4, 1, 3, 0, 0, 1, 0, '0);
        tbl[7]  = mk(1, 9, 12, 0, 3, 0, 1, 1, 0, mem[3]);
        tbl[8]  = mk(0, 2, 4, 1, 3, 0, 1, 1, 0, mem[3]);
        tbl[9]  = mk(0, 2, 4, 1, 4, 1, 0, 1, 0, '0);
        tbl[10] = mk(0, 2, 4, 1, 4, 0, 0, 1, 0, '0);
        tbl[11] = mk(0, 2, 4, 1, 4, 0, 1, 1, 0, mem[4]);
        tbl[12] = mk(0, 2, 4, 1, 4, 0, 1, 1, 0, mem[4]);
        tbl[13] = mk(0, 2, 4, 1, 4, 0, 0, 1, 1, '0);
        tbl[14] = mk(0, 2, 4, 1, 4, 0, 0, 0, 0, '0);

        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            bus.start_i = tbl[r].start;
            bus.first_addrs_i = tbl[r].first;
            bus.last_addrs_i = tbl[r].last;
            bus.hold_cycles_i = tbl[r].hold;
            bus.stall_i = 1'b0;
            check($sformatf("row%0d_addr", r), 64'(bus.addrs_rom_signal_o), 64'(tbl[r].e_addr));
            check($sformatf("row%0d_rd", r), 64'(bus.rd_rom_signals_ld_o), 64'(tbl[r].e_rd));
            check($sformatf("row%0d_valid", r), 64'(bus.signals_valid_o), 64'(tbl[r].e_valid));
            check($sformatf("row%0d_busy", r), 64'(bus.busy_o), 64'(tbl[r].e_busy));
            check($sformatf("row%0d_done", r), 64'(bus.done_o), 64'(tbl[r].e_done));
            check($sformatf("row%0d_signals", r), 64'(bus.signals_o), 64'(tbl[r].e_sig));
        end
        bus.start_i = 1'b0;

        // Start in the DONE cycle is dropped; start in the following IDLE cycle runs.
        @(negedge clk); bus.start_i = 1'b1; bus.first_addrs_i = 7; bus.last_addrs_i = 7; bus.hold_cycles_i = 0;
        @(negedge clk); bus.start_i = 1'b0;
        check("rs_fetch_addr", 64'(bus.addrs_rom_signal_o), 64'd7);
        @(negedge clk);
        @(negedge clk);
        check("rs_hold_signals", 64'(bus.signals_o), 64'(mem[7]));
        @(negedge clk);
        check("rs_done", 64'(bus.done_o), 64'd1);
        bus.start_i = 1'b1; bus.first_addrs_i = 8; bus.last_addrs_i = 8;
        @(negedge clk);
        check("rs_done_start_ignored", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
        check("rs_idle_start_rd", 64'(bus.rd_rom_signals_ld_o), 64'd1);
        check("rs_idle_start_addr", 64'(bus.addrs_rom_signal_o), 64'd8);
        bus.start_i = 1'b0;
        for (int i = 0; i < 10 && bus.busy_o; i++) @(negedge clk);
        check("rs_drained", 64'(bus.busy_o), 64'd0);

        // Wrap from address 14 through 15 to 1, one cycle per word
        run_seq(14, 1, 0, 0, 0, 40);
        check_s("wrap_addrs", rd_s, "14,15,0,1,");
        check_s("wrap_runs", run_s, "1,1,1,1,");
        check("wrap_end_cycle", 64'(end_cycle), 64'd14);

        // Single word with two stalled HOLD cycles
        run_seq(5, 5, 3, 4, 2, 40);
        check_s("stall_addrs", rd_s, "5,");
        check_s("stall_runs", run_s, "6,");
        check("stall_first_valid", 64'(first_valid), 64'd3);
        check("stall_end_cycle", 64'(end_cycle), 64'd10);

        // Maximum hold count
        run_seq(9, 9, 8'd255, 0, 0, 300);
        check_s("maxhold_addrs", rd_s, "9,");
        check_s("maxhold_runs", run_s, "256,");
        check("maxhold_end_cycle", 64'(end_cycle), 64'd260);

        // Asynchronous reset in the middle of HOLD, then a fresh run
        @(negedge clk); bus.start_i = 1'b1; bus.first_addrs_i = 1; bus.last_addrs_i = 3; bus.hold_cycles_i = 5;
        @(negedge clk); bus.start_i = 1'b0;
        for (int i = 0; i < 10 && !bus.signals_valid_o; i++) @(negedge clk);
        check("mid_wait_valid", 64'(bus.signals_valid_o), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_signals", 64'(bus.signals_o), 64'd0);
        check("mid_rst_valid", 64'(bus.signals_valid_o), 64'd0);
        check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        check("mid_rst_done", 64'(bus.done_o), 64'd0);
        check("mid_rst_rd", 64'(bus.rd_rom_signals_ld_o), 64'd0);
        check("mid_rst_addr", 64'(bus.addrs_rom_signal_o), 64'd0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) dn++;
        end
        check("mid_rst_quiet", 64'(dn), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_seq(3, 5, 1, 0, 0, 40);
        check_s("post_rst_addrs", rd_s, "3,4,5,");
        check_s("post_rst_runs", run_s, "2,2,2,");
        check("post_rst_first_valid", 64'(first_valid), 64'd3);
        check("post_rst_end_cycle", 64'(end_cycle), 64'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/signal_sequencer.md
SIGNAL_SEQUENCER -- requirements
Module: signal_sequencer

Interface
REQ-001 SHALL have parameter MEMORY_WIDTH, default 63, control-word width; equals the signal memory word width.
REQ-002 SHALL have parameter ADDRS_WIDTH, default 4, signal memory address width.
REQ-003 SHALL have parameter HOLD_WIDTH, default 8, hold-count width.
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 start_i  input  1  one-cycle request to run a sequence.
REQ-007 first_addrs_i  input  ADDRS_WIDTH  first memory address of sequence; sampled on accepted start.
REQ-008 last_addrs_i  input  ADDRS_WIDTH  last memory address of sequence; sampled on accepted start.
REQ-009 hold_cycles_i  input  HOLD_WIDTH  each word is presented for hold_cycles_i+1 cycles; sampled on accepted start.
REQ-010 stall_i  input  1  freezes hold countdown while high.
REQ-011 rom_signals_data_i  input  MEMORY_WIDTH  registered read data from signal memory.
REQ-012 addrs_rom_signal_o  output  ADDRS_WIDTH  read address to signal memory.
REQ-013 rd_rom_signals_ld_o  output  1  read strobe to signal memory.
REQ-014 signals_o  output  MEMORY_WIDTH  registered control word to datapath.
REQ-015 signals_valid_o  output  1  signals_o is valid this cycle.
REQ-016 busy_o  output  1  sequence in progress.
REQ-017 done_o  output  1  one-cycle pulse on sequence completion.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, LATCH, HOLD, DONE.
REQ-019 IDLE: start_i=1 -> capture first/last/hold into registers, cur_addr<=first_addrs_i, go FETCH; otherwise stay.
REQ-020 FETCH (1 cycle): rd_rom_signals_ld_o=1, addrs_rom_signal_o=cur_addr; go LATCH.
REQ-021 LATCH (1 cycle): rd_rom_signals_ld_o=0; signals_o<=rom_signals_data_i at end of cycle; hold counter<=captured hold; go HOLD.
REQ-022 HOLD: signals_valid_o=1, signals_o constant; counter decrements each cycle with stall_i=0, unchanged with stall_i=1.
REQ-023 HOLD exit on cycle with counter=0 and stall_i=0: if cur_addr=last -> DONE; else cur_addr<=cur_addr+1 modulo 2^ADDRS_WIDTH, go FETCH.
REQ-024 DONE (1 cycle): done_o=1; go IDLE.
REQ-025 Start-to-first-valid latency: start accepted at edge n -> signals_valid_o first high in cycle n+3.
REQ-026 Word count = ((last-first) mod 2^ADDRS_WIDTH)+1; first>last wraps through max address to 0; first=last runs exactly one word.
REQ-027 Per-word period = hold+3 cycles absent stall (FETCH, LATCH, hold+1 HOLD).
REQ-028 signals_o SHALL be all-zero and signals_valid_o 0 in every state except HOLD.
REQ-029 addrs_rom_signal_o SHALL equal cur_addr in all states; rd_rom_signals_ld_o high only in FETCH.
REQ-030 busy_o=1 in FETCH, LATCH, HOLD, DONE; 0 in IDLE.
REQ-031 start_i while busy_o=1 SHALL be ignored; a start in the DONE cycle is ignored; a start in the IDLE cycle following DONE is accepted.
REQ-032 Changes on first/last/hold inputs while busy SHALL NOT affect the running sequence.

Reset
REQ-033 rst_n_i=0 SHALL immediately force IDLE, cur_addr=0, hold counter=0, signals_o=0, all 1-bit outputs 0, addrs_rom_signal_o=0, regardless of state, including mid-HOLD.
REQ-034 After rst_n_i deasserts, the block SHALL accept start_i on the first rising edge.

Verification
REQ-035 first=2,last=4,hold=1, memory words 2..4 = A,B,C, start at edge 0 -> rd strobes in cycles 1,5,9 at addrs 2,3,4; signals_o=A cycles 3-4, B 7-8, C 11-12; done_o cycle 13; busy_o low cycle 14.
REQ-036 first=14,last=1,hold=0 (ADDRS_WIDTH=4) -> addresses read 14,15,0,1; four words each valid 1 cycle; one done_o pulse.
REQ-037 first=last=5,hold=3, stall_i high for 2 cycles during HOLD -> signals_valid_o high 6 cycles, single read, single done_o.
REQ-038 start_i pulsed during HOLD with different first/last -> ignored; sequence completes with original addresses.
REQ-039 rst_n_i pulsed low mid-HOLD -> outputs zero asynchronously, no done_o; new start after release runs full sequence correctly.
REQ-040 hold=255 (max) -> each word valid exactly 256 cycles; no counter wrap.
